// File: rtl/seq_multiplier.sv
// Sequential shift-and-add unsigned multiplier.
// One partial product is accumulated per RUN cycle; the result is loaded
// onto product when the FSM enters DONE and held there until the next DONE.
// Optional feature: define SEQ_MULT_EARLY_EXIT_EN to leave RUN as soon as
// the remaining multiplier bits are all zero (product values are unchanged).
//
// Handshake: start is a level request sampled at each rising edge; it is
// taken only in IDLE or DONE and ignored in RUN. done is a one-cycle pulse
// marking the first cycle in which product holds the new result. busy and
// done are mutually exclusive.
module seq_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;

    logic [2*WIDTH-1:0] acc_next;
    logic               run_last;

    // Partial-product add and end-of-run detection for the current RUN cycle.
    always_comb begin
        acc_next = acc + (mplier[0] ? mcand : '0);
`ifdef SEQ_MULT_EARLY_EXIT_EN
        // Post-shift multiplier is zero when every bit above the LSB is zero.
        run_last = (cnt == CW'(WIDTH - 1)) || (mplier[WIDTH-1:1] == '0);
`else
        run_last = (cnt == CW'(WIDTH - 1));
`endif
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start is honoured only outside RUN.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (run_last) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: busy only in RUN, done only in DONE.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand capture on accept, shift-and-add in RUN, and
    // product load on the final RUN edge so it is valid with done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, multiplicand};
                        mplier <= multiplier;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (run_last) begin
                        product <= acc_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 4: operand width in bits, legal range 2..16.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port start  input  1  request to begin a multiplication.
REQ-005 SHALL have port multiplicand  input  WIDTH  unsigned operand A.
REQ-006 SHALL have port multiplier  input  WIDTH  unsigned operand B.
REQ-007 SHALL have port busy  output  1  high while a multiplication is in progress.
REQ-008 SHALL have port done  output  1  single-cycle pulse when the product becomes valid.
REQ-009 SHALL have port product  output  2*WIDTH  unsigned A*B result.

Function
REQ-010 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-011 SHALL accept start only in IDLE or DONE: latch both operands, clear the accumulator and the bit counter, and enter RUN.
REQ-012 SHALL ignore start while in RUN; the latched operands and the in-flight result SHALL be unaffected.
REQ-013 SHALL, on each RUN cycle: if the multiplier register LSB is 1, add the multiplicand register (2*WIDTH wide) to the accumulator; then shift the multiplicand left by 1, shift the multiplier right by 1, and increment the counter.
REQ-014 SHALL perform the accumulation at 2*WIDTH bits with no overflow possible; the upper bits are zero-extended.
REQ-015 SHALL, without the early-exit option, leave RUN after exactly WIDTH cycles and enter DONE.
REQ-016 SHALL, in DONE, assert done for exactly one cycle and load the accumulator onto product; DONE SHALL return to IDLE on the next edge unless start is high.
REQ-017 SHALL hold product stable from the done cycle until the cycle after the next accepted start, at which point product is not updated until the next done.
REQ-018 SHALL assert busy in RUN only; busy and done SHALL never be high together.
REQ-019 SHALL have latency, without the early-exit option, of WIDTH+1 cycles from the start-accept edge to the done-high cycle.
REQ-020 SHALL accept start during the DONE cycle (back-to-back); done still pulses for the finished result and RUN begins on the next edge.
REQ-021 SHALL produce the following edge-case results: A=0 or B=0 gives product 0; the maximum operands give (2^WIDTH-1)^2 with no truncation.

Reset
REQ-022 SHALL, when rst_n is low at a rising edge, set state to IDLE, busy=0, done=0, product=0, and clear the accumulator, counter and operand registers.
REQ-023 SHALL abort any operation in progress on reset with no done pulse; start is ignored during any cycle in which rst_n is low.
REQ-024 SHALL accept start on the first edge after rst_n returns high.

Configuration
REQ-025 SHALL use macro SEQ_MULT_EARLY_EXIT_EN.
REQ-026 SHALL, when SEQ_MULT_EARLY_EXIT_EN is defined, leave RUN after the cycle in which the post-shift multiplier register is zero or the counter reaches WIDTH, whichever comes first. RUN lasts max(1, index of B's highest set bit + 1) cycles, and latency equals that count + 1.
REQ-027 SHALL, when SEQ_MULT_EARLY_EXIT_EN is undefined, use fixed WIDTH-cycle RUN; product values SHALL be identical in both builds.

Verification (WIDTH=4)
REQ-028 SHALL cover: A=15, B=15, start one cycle -> busy high 4 cycles, done pulse 5 cycles after accept, product=225 (0xE1).
REQ-029 SHALL cover: A=9, B=3 -> product=27. Then A=0, B=7 -> product=0 and product holds 27 until the second accept.
REQ-030 SHALL cover: start re-asserted with A=2, B=2 during RUN of 6*5 -> ignored; product=30 and exactly one done pulse.
REQ-031 SHALL cover: rst_n low on the 2nd RUN cycle of 7*7 -> next cycle busy=0, done=0, product=0, and no done pulse follows.
REQ-032 SHALL cover: start held high continuously with operands 3*4 then 5*5 -> back-to-back done pulses every 5 cycles, products 12 then 25.
REQ-033 SHALL cover, with SEQ_MULT_EARLY_EXIT_EN defined: A=13, B=1 -> RUN 1 cycle, done 2 cycles after accept, product=13; and A=13, B=8 -> RUN 4 cycles, product=104.
